bcd_converter_seq: RTL and testbench
====================================

Name: bcd_converter_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). One shift step per clock.
- Sits directly downstream of the 8-bit T-flip-flop counter. Takes its binary count and produces decimal digits for the seven-segment display decoders.
- Start/busy/valid handshake. Result is held stable between conversions, so the display never shows a partial value.

Parameters:
- WIDTH, 8, binary input width in bits; also the number of shift cycles per conversion.
- DIGITS, 3, number of BCD output digits. Legal only if 10^DIGITS > 2^WIDTH - 1.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_clear  input  1  synchronous, active-high reset.
- i_start  input  1  request a conversion; sampled only in IDLE.
- i_bin  input  WIDTH  binary value; captured on the accepting edge.
- o_busy  output  1  high while a conversion is in progress.
- o_valid  output  1  one-cycle pulse when o_bcd has just been updated.
- o_bcd  output  4*DIGITS  result; digit k is bits [4k+3:4k], digit 0 = ones.

Behaviour:
- Interface: one clock (i_clk). Reset i_clear is synchronous and active-high.
- Reset: when i_clear is high at an edge:
  - state goes to IDLE; o_bcd = 0; o_valid = 0; o_busy = 0; shift register and step counter = 0.
  - i_clear has priority over every other input.
- States: IDLE, SHIFT.
- IDLE:
  - o_busy = 0.
  - On an edge with i_start = 1, load the working register with {DIGITS*4 zeros, i_bin}, set step counter = 0, go to SHIFT.
  - o_busy goes high after that edge.
- SHIFT, once per edge:
  - For each BCD nibble of the working register, add 3 if the nibble is >= 5.
  - Then shift the whole register left by 1.
  - Increment the step counter.
- Completion: the edge that performs step WIDTH (counter reaching WIDTH-1 before the step) does all of the following:
  - writes the BCD field of the shifted result to o_bcd;
  - sets o_valid = 1 for exactly one cycle;
  - clears o_busy;
  - returns to IDLE.
- Latency: accept edge E0; o_valid and the new o_bcd are visible after edge E(WIDTH), i.e. 8 edges later by default. o_busy is high for exactly WIDTH cycles.
- Start while busy: i_start in SHIFT is ignored and not queued. i_bin changes during SHIFT have no effect.
- Back-to-back: in the cycle o_valid = 1 the state is IDLE, so i_start = 1 is accepted at the next edge. i_start held high gives one conversion every WIDTH+1 cycles.
- o_bcd holding:
  - changes only at a completion edge or at reset;
  - holds its value through IDLE and SHIFT.
- Reset mid-conversion:
  - aborts; no o_valid pulse;
  - o_bcd goes to 0 (not the partial result);
  - the next conversion starts only on a fresh i_start after i_clear goes low.
- Arithmetic:
  - working register is 4*DIGITS + WIDTH bits; add-3 is applied to nibbles only, never to the binary tail;
  - no nibble of the final result exceeds 9 for any legal input;
  - with default parameters, o_bcd[11:8] is never above 2.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then i_bin=0 with a one-cycle i_start: o_busy high for 8 cycles, then o_valid pulse, o_bcd=12'h000.
- i_bin=255 with i_start at edge E0: o_valid=1 only after E8 and o_bcd=12'h255. i_bin changed to 3 during SHIFT leaves the result at 12'h255.
- Convert 99 (o_bcd=12'h099), then pulse i_start again at cycle E3 of a conversion of 128: the extra start is ignored, exactly one o_valid, o_bcd=12'h128.
- Assert i_clear at SHIFT step 4 of a conversion of 200: no o_valid, o_bcd=0, o_busy=0 next cycle. A later conversion of 7 gives 12'h007.
- i_start tied high with i_bin driven by the 8-bit counter, enable stepping once per valid: o_valid every 9 cycles. All 256 results match the decimal reference and o_bcd is stable between pulses.
- Back-to-back 128 then 7, with i_start in the o_valid cycle: second o_valid exactly 9 cycles after the first, with 12'h007.

Source files
------------

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (double dabble), one shift step per clock.
// Start/busy/valid handshake; o_bcd only changes on a completed conversion or reset.
module bcd_converter_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int TOT_W = BCD_W + WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e             state_q, state_d;
  logic [TOT_W-1:0]   work_q, work_d;
  logic [TOT_W-1:0]   adjusted;
  logic [TOT_W-1:0]   shifted;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               last_step;

  assign last_step = (step_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      state_q <= IDLE;
      work_q  <= '0;
      step_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      step_q  <= step_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start)   state_d = SHIFT;
      SHIFT:   if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 touches only the BCD nibbles above the binary tail, then the whole register shifts.
  always_comb begin
    adjusted = work_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_q[WIDTH+4*d +: 4] >= 4'd5)
        adjusted[WIDTH+4*d +: 4] = work_q[WIDTH+4*d +: 4] + 4'd3;
    end
    shifted = {adjusted[TOT_W-2:0], 1'b0};
  end

  always_comb begin
    work_d  = work_q;
    step_d  = step_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          work_d = {{BCD_W{1'b0}}, i_bin};
          step_d = '0;
          busy_d = 1'b1;
        end
      end
      SHIFT: begin
        work_d = shifted;
        step_d = step_q + CNT_W'(1);
        if (last_step) begin
          bcd_d   = shifted[TOT_W-1 -: BCD_W];
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    o_busy  = busy_q;
    o_valid = valid_q;
    o_bcd   = bcd_q;
  end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed self-checking bench for bcd_converter_seq with default parameters.
module tb_bcd_converter_seq;

  logic        i_clk;
  logic        i_clear;
  logic        i_start;
  logic [7:0]  i_bin;
  logic        o_busy;
  logic        o_valid;
  logic [11:0] o_bcd;

  int num_asserts = 0;
  int num_fail    = 0;

  bcd_converter_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .i_clk   (i_clk),
    .i_clear (i_clear),
    .i_start (i_start),
    .i_bin   (i_bin),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_bcd   (o_bcd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_asserts++;
    assert (obs === exp) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] bin);
    i_bin   = bin;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Ticks until o_valid rises (bounded); reports cycles taken and whether o_bcd moved early.
  task automatic waitValid(output int cycles, output bit unstable);
    logic [11:0] held;
    held     = o_bcd;
    cycles   = 0;
    unstable = 1'b0;
    do begin
      tick();
      cycles++;
      if (o_valid !== 1'b1 && o_bcd !== held) unstable = 1'b1;
    end while (o_valid !== 1'b1 && cycles < 20);
  endtask

  function automatic logic [11:0] decRef(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  initial begin
    int cycles;
    int extra;
    bit unstable;
    bit any_unstable;
    bit any_bad;

    i_clear = 1'b1;
    i_start = 1'b0;
    i_bin   = 8'd0;
    tick();
    tick();
    i_clear = 1'b0;
    checkOutput("reset_bcd",   32'(o_bcd),   32'h000);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_busy",  32'(o_busy),  32'd0);

    // Zero input: busy for exactly eight cycles, then a single valid pulse.
    applyStimulus(8'd0);
    any_bad = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (o_busy !== 1'b1 || o_valid !== 1'b0) any_bad = 1'b1;
      tick();
    end
    checkOutput("zero_busy_window", 32'(any_bad), 32'd0);
    checkOutput("zero_busy_last",   32'(o_busy),  32'd1);
    tick();
    checkOutput("zero_valid", 32'(o_valid), 32'd1);
    checkOutput("zero_busy_done", 32'(o_busy), 32'd0);
    checkOutput("zero_bcd",   32'(o_bcd),   32'h000);
    tick();
    checkOutput("zero_valid_pulse", 32'(o_valid), 32'd0);

    // 255 with the input changed mid-conversion.
    applyStimulus(8'd255);
    i_bin = 8'd3;
    waitValid(cycles, unstable);
    checkOutput("max_latency", 32'(cycles), 32'd8);
    checkOutput("max_bcd",     32'(o_bcd),  32'h255);
    checkOutput("max_hold",    32'(unstable), 32'd0);
    tick();

    applyStimulus(8'd99);
    waitValid(cycles, unstable);
    checkOutput("n99_bcd", 32'(o_bcd), 32'h099);
    tick();

    // Extra start during SHIFT must be ignored.
    applyStimulus(8'd128);
    tick();
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    waitValid(cycles, unstable);
    checkOutput("ign_latency", 32'(cycles), 32'd5);
    checkOutput("ign_bcd",     32'(o_bcd),  32'h128);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (o_valid === 1'b1 || o_busy === 1'b1) extra++;
    end
    checkOutput("ign_no_second", 32'(extra), 32'd0);
    checkOutput("ign_bcd_hold",  32'(o_bcd), 32'h128);

    // Abort a conversion of 200 at step 4.
    applyStimulus(8'd200);
    tick();
    tick();
    tick();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    checkOutput("abort_valid", 32'(o_valid), 32'd0);
    checkOutput("abort_busy",  32'(o_busy),  32'd0);
    checkOutput("abort_bcd",   32'(o_bcd),   32'h000);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_valid === 1'b1 || o_busy === 1'b1) extra++;
    end
    checkOutput("abort_quiet", 32'(extra), 32'd0);
    applyStimulus(8'd7);
    waitValid(cycles, unstable);
    checkOutput("after_abort_latency", 32'(cycles), 32'd8);
    checkOutput("after_abort_bcd",     32'(o_bcd),  32'h007);
    tick();

    // Start held high, input stepping like the upstream counter once per valid.
    i_bin   = 8'd0;
    i_start = 1'b1;
    any_unstable = 1'b0;
    for (int n = 0; n < 256; n++) begin
      waitValid(cycles, unstable);
      if (unstable) any_unstable = 1'b1;
      checkOutput($sformatf("sweep_period_%0d", n), 32'(cycles), 32'd9);
      checkOutput($sformatf("sweep_bcd_%0d", n),    32'(o_bcd),  32'(decRef(n)));
      i_bin = 8'(n + 1);
    end
    i_start = 1'b0;
    checkOutput("sweep_stable", 32'(any_unstable), 32'd0);
    tick();
    tick();

    // Back-to-back: second start issued in the valid cycle of the first.
    applyStimulus(8'd128);
    waitValid(cycles, unstable);
    checkOutput("b2b_first_bcd", 32'(o_bcd), 32'h128);
    i_bin   = 8'd7;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checkOutput("b2b_busy", 32'(o_busy), 32'd1);
    waitValid(cycles, unstable);
    checkOutput("b2b_spacing", 32'(cycles + 1), 32'd9);
    checkOutput("b2b_bcd",     32'(o_bcd),      32'h007);
    tick();
    checkOutput("b2b_valid_pulse", 32'(o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fail);
    $finish;
  end

endmodule
